// File: rtl/alu_ops.sv
// alu_ops: shared operand width and 4-bit ALU operation codes for the uCode datapath.
// Ports: none (package only).
// Codes 9..15 are unused and treated as NO_OP by the ALU.
package alu_ops;

  localparam int WIDTH = 16;

  localparam logic [3:0] NO_OP  = 4'd0;
  localparam logic [3:0] ADD_OP = 4'd1;
  localparam logic [3:0] SUB_OP = 4'd2;
  localparam logic [3:0] AND_OP = 4'd3;
  localparam logic [3:0] OR_OP  = 4'd4;
  localparam logic [3:0] XOR_OP = 4'd5;
  localparam logic [3:0] ROL_OP = 4'd6;
  localparam logic [3:0] ROR_OP = 4'd7;
  localparam logic [3:0] ASR_OP = 4'd8;

endpackage

// File: rtl/alu_lifo_alu.sv
// alu: registered ALU, result appears on o_data one cycle after the operands.
// Ports: i_clk, i_rst_n (async active-low), i_op, i_arg0, i_arg1 in; o_data out.
// No backpressure: a new operation is accepted on every rising edge.
module alu
  import alu_ops::*;
#(
  parameter int WIDTH = alu_ops::WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] result;

  // Unused codes fall into default and hold, like NO_OP.
  // Carry/overflow are simply dropped by the WIDTH-bit assignment.
  always_comb begin
    result = o_data;
    case (i_op)
      ADD_OP:  result = i_arg0 + i_arg1;
      SUB_OP:  result = i_arg0 - i_arg1;
      AND_OP:  result = i_arg0 & i_arg1;
      OR_OP:   result = i_arg0 | i_arg1;
      XOR_OP:  result = i_arg0 ^ i_arg1;
      ROL_OP:  result = {i_arg0[WIDTH-2:0], i_arg0[WIDTH-1]};
      ROR_OP:  result = {i_arg0[0], i_arg0[WIDTH-1:1]};
      ASR_OP:  result = {i_arg0[WIDTH-1], i_arg0[WIDTH-1:1]};
      default: result = o_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else begin
      o_data <= result;
    end
  end

endmodule

// File: rtl/alu_lifo.sv
// alu_lifo: uCode CPU datapath -- registered ALU (1-cycle) plus a shift-register LIFO.
// Ports: i_clk, i_rst_n, ALU (i_op, i_arg0, i_arg1 -> o_data), LIFO (i_data, i_push, i_pop -> o_s0, o_s1).
// No handshake: strobes are honoured every cycle; push/pop visible on o_s0/o_s1 the cycle after.
module alu_lifo
  import alu_ops::*;
#(
  parameter int WIDTH = alu_ops::WIDTH,
  parameter int DEPTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  output logic [WIDTH-1:0] o_data,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1
);

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_op    (i_op),
    .i_arg0  (i_arg0),
    .i_arg1  (i_arg1),
    .o_data  (o_data)
  );

  // Each cell shifts down on push (towards deeper cells) and up on pop.
  // The deepest cell is lost on push and refilled with zero on pop, so
  // overflow silently drops the oldest value and underflow reads zeros.
  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_cell
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] above;
    logic [WIDTH-1:0] below;

    if (k == 0) begin : g_top
      assign above = i_data;
    end else begin : g_mid
      assign above = g_cell[k-1].q;
    end

    if (k == DEPTH-1) begin : g_bot
      assign below = '0;
    end else begin : g_up
      assign below = g_cell[k+1].q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        q <= '0;
      end else begin
        case ({i_push, i_pop})
          2'b10:   q <= above;
          2'b01:   q <= below;
          // Replace: only the top cell takes i_data, depth is unchanged.
          2'b11:   if (k == 0) q <= above;
          default: q <= q;
        endcase
      end
    end
  end

  assign o_s0 = g_cell[0].q;
  assign o_s1 = g_cell[1].q;

endmodule

// File: tb/tb_alu_lifo.sv
module tb_alu_lifo;
  localparam int W = 16;
  localparam int D = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] o_data;
  logic [W-1:0] din = '0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] s0;
  logic [W-1:0] s1;

  int passed = 0;
  int total  = 0;

  logic [W-1:0]   m[$];   // reference stack, m[0] is top
  logic [2*W-1:0] lq[$];  // expected {s0,s1} after each edge
  logic [W-1:0]   aq[$];  // expected o_data after an ALU edge

  always #5 clk = ~clk;

  alu_lifo #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_op    (op),
    .i_arg0  (a0),
    .i_arg1  (a1),
    .o_data  (o_data),
    .i_data  (din),
    .i_push  (push),
    .i_pop   (pop),
    .o_s0    (s0),
    .o_s1    (s1)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m = {};
    repeat (D) m.push_back('0);
  endtask

  // Apply currently driven inputs for one edge; model predicts, queue compares.
  task automatic tick(input string tag);
    logic [2*W-1:0] e;
    if (push && pop) begin
      m[0] = din;
    end else if (push) begin
      m.push_front(din);
      void'(m.pop_back());
    end else if (pop) begin
      void'(m.pop_front());
      m.push_back('0);
    end
    lq.push_back({m[0], m[1]});
    @(posedge clk);
    #1;
    e = lq.pop_front();
    chk({tag, ".s0"}, s0, e[2*W-1:W]);
    chk({tag, ".s1"}, s1, e[W-1:0]);
    if (aq.size() > 0) chk({tag, ".alu"}, o_data, aq.pop_front());
    push = 1'b0;
    pop  = 1'b0;
    op   = 4'd0;
  endtask

  task automatic do_alu(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp);
    op = o; a0 = x; a1 = y;
    aq.push_back(exp);
    tick(tag);
  endtask

  task automatic do_push(input logic [W-1:0] v);
    din = v; push = 1'b1;
    tick("push");
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick("pop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total %0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset at start, checked without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.alu", o_data, 16'h0000);
    chk("rst.s0", s0, 16'h0000);
    chk("rst.s1", s1, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // ALU directed
    do_alu("add_wrap", 4'd1, 16'hFFFF, 16'h0001, 16'h0000);
    do_alu("sub",      4'd2, 16'h0003, 16'h0005, 16'hFFFE);
    do_alu("and",      4'd3, 16'hF0F0, 16'h3C3C, 16'h3030);
    do_alu("or",       4'd4, 16'hF0F0, 16'h0F01, 16'hFFF1);
    do_alu("xor",      4'd5, 16'hAAAA, 16'hFFFF, 16'h5555);
    do_alu("rol",      4'd6, 16'h8001, 16'hFFFF, 16'h0003);
    do_alu("ror",      4'd7, 16'h0001, 16'hFFFF, 16'h8000);
    do_alu("asr",      4'd8, 16'h8004, 16'h1234, 16'hC002);
    do_alu("noop",     4'd0, 16'h1234, 16'h0001, 16'hC002);
    do_alu("op15",     4'd15, 16'h1111, 16'h2222, 16'hC002);
    do_alu("op9",      4'd9, 16'h0001, 16'h0001, 16'hC002);

    // LIFO push/pop and underflow
    do_push(16'd1);
    do_push(16'd2);
    do_push(16'd3);
    chk("push3.s0", s0, 16'd3);
    chk("push3.s1", s1, 16'd2);
    do_pop();
    chk("pop1.s0", s0, 16'd2);
    chk("pop1.s1", s1, 16'd1);
    do_pop();
    do_pop();
    chk("empty.s0", s0, 16'd0);
    chk("empty.s1", s1, 16'd0);
    do_pop();
    chk("under.s0", s0, 16'd0);

    // Replace
    do_push(16'd5);
    do_push(16'd7);
    din = 16'd9; push = 1'b1; pop = 1'b1;
    tick("replace");
    chk("repl.s0", s0, 16'd9);
    chk("repl.s1", s1, 16'd5);
    do_pop();
    do_pop();
    chk("repl.depth", s0, 16'd0);

    // Overflow: oldest value dropped
    for (int i = 1; i <= D + 1; i++) do_push(W'(i));
    for (int i = 0; i < D - 1; i++) do_pop();
    chk("ovf.last", s0, 16'd2);
    do_pop();
    chk("ovf.after", s0, 16'd0);

    // Back-to-back alternating traffic, occasional replace
    for (int i = 0; i < 100; i++) begin
      din = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        push = 1'b1; pop = 1'b1;
      end else if (i % 2 == 0) begin
        push = 1'b1;
      end else begin
        pop = 1'b1;
      end
      tick("rand");
    end

    // Mid-stream async reset with strobe and ALU op pending
    do_push(16'h1234);
    do_alu("pre_rst", 4'd1, 16'h0001, 16'h0001, 16'h0002);
    din = 16'hAAAA; push = 1'b1; op = 4'd1; a0 = 16'h0005; a1 = 16'h0005;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.alu", o_data, 16'h0000);
    chk("mrst.s0", s0, 16'h0000);
    chk("mrst.s1", s1, 16'h0000);
    @(posedge clk);
    #1;
    chk("mrst_hold.alu", o_data, 16'h0000);
    chk("mrst_hold.s0", s0, 16'h0000);
    rst_n = 1'b1;
    push = 1'b0; op = 4'd0;
    model_reset();
    do_push(16'h0004);
    chk("post_rst.s0", s0, 16'h0004);
    chk("post_rst.s1", s1, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
